serial_addsub15: RTL and testbench



---
 rtl/serial_addsub15.sv | 130 +++++++++++++
 tb/tb_serial_addsub15.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub15.sv
// Bit-serial two's-complement adder/subtractor: operands are latched on start and
// shifted LSB-first through one full adder, one bit per clock, carry held in a flop.

module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Carry
);
  assign S     = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

module serial_addsub15 #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Carry,
  output logic             Overflow,
  output logic [1:0]       dbg_state_o
);
  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // results are valid and stable from the done pulse until the next done pulse.
  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             fa_s, fa_carry, accept, last_bit;

  fullAdder u_fa (
    .A     (ra_q[0]),
    .B     (rb_q[0]),
    .Cin   (c_q),
    .S     (fa_s),
    .Carry (fa_carry)
  );

  assign accept   = (state_q != RUN) && start;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last_bit ? DONE : RUN;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    dbg_state_o = state_q;
  end

  // Datapath: subtraction is A + ~B + 1, with the +1 entering as the initial carry.
  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      ra_d  = A;
      rb_d  = B ^ {WIDTH{mode}};
      c_d   = mode;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      ra_d  = ra_q >> 1;
      rb_d  = rb_q >> 1;
      c_d   = fa_carry;
      cnt_d = cnt_q + CW'(1);
      res_d = {fa_s, res_q[WIDTH-1:1]};
      if (last_bit) begin
        s_d     = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        ovf_d   = c_q ^ fa_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q    <= '0;
      rb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S        = s_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub15.sv
// Bench for serial_addsub15: hand-computed vector table, random operations against
// an arithmetic reference model, plus mid-run start, back-to-back and reset sequences.
`timescale 1ns/1ps

module tb_serial_addsub15;
  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, carry_out, ovf_out;
  logic [W-1:0] s_out;
  logic [1:0]   dbg_state;

  serial_addsub15 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .S           (s_out),
    .Carry       (carry_out),
    .Overflow    (ovf_out),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];        // {carry, overflow, sum}
  logic [W+1:0] last_exp = '0;   // last completed result the outputs must hold

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain signed/unsigned integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int sa, sb, ua, ub, r;
    logic c, v;
    logic [W-1:0] s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = m ? sa - sb : sa + sb;
    v  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    c  = m ? (ua >= ub) : ((ua + ub) >= (2 ** W));
    s  = r[W-1:0];
    return {c, v, s};
  endfunction

  // Driver: call at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W+1:0] exp);
    a_in  = a;
    b_in  = b;
    mode  = m;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one operation and scores it; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W+1:0] exp_in, input string name);
    logic [W+1:0] exp;
    int busy_cycles;
    bit seen, held;
    launch(a, b, m, exp_in);
    busy_cycles = 0;
    seen = 0;
    held = 1;
    for (int k = 0; k < W + 4; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cycles++;
      if ({carry_out, ovf_out, s_out} !== last_exp) held = 0;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    check({name, " done"}, 32'(seen), 32'd1);
    check({name, " busy_cycles"}, 32'(busy_cycles), 32'(W));
    check({name, " held"}, 32'(held), 32'd1);
    check({name, " S"}, 32'(s_out), 32'(exp[W-1:0]));
    check({name, " Carry"}, 32'(carry_out), 32'(exp[W+1]));
    check({name, " Overflow"}, 32'(ovf_out), 32'(exp[W]));
    last_exp = exp;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    check({name, " S"}, 32'(s_out), 32'd0);
    check({name, " Carry"}, 32'(carry_out), 32'd0);
    check({name, " Overflow"}, 32'(ovf_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rm;
    bit           seen, quiet;

    //                 a        b        m     s        c     v
    vecs[0] = '{15'd100,  15'd23,   1'b0, 15'd123,  1'b0, 1'b0};
    vecs[1] = '{15'h3FFF, 15'h0001, 1'b0, 15'h4000, 1'b0, 1'b1};
    vecs[2] = '{15'd5,    15'd7,    1'b1, 15'h7FFE, 1'b0, 1'b0};
    vecs[3] = '{15'h4000, 15'h0001, 1'b1, 15'h3FFF, 1'b1, 1'b1};
    vecs[4] = '{15'h7FFF, 15'h0001, 1'b0, 15'h0000, 1'b1, 1'b0};
    vecs[5] = '{15'h0001, 15'h0001, 1'b1, 15'h0000, 1'b1, 1'b0};
    vecs[6] = '{15'h0000, 15'h0000, 1'b1, 15'h0000, 1'b1, 1'b0};
    vecs[7] = '{15'h4000, 15'h4000, 1'b1, 15'h0000, 1'b1, 1'b0};
    vecs[8] = '{15'h0000, 15'h4000, 1'b1, 15'h4000, 1'b0, 1'b1};

    #2;
    check_outputs_zero("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_idle");

    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, {vecs[i].c, vecs[i].v, vecs[i].s},
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      run_op(ra, rb, rm, model(ra, rb, rm), $sformatf("rand%0d", i));
    end

    // start during RUN is ignored; start in the done cycle runs with no gap
    @(negedge clk);
    a_in  = 15'h0010;
    b_in  = 15'h0020;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a_in  = 15'h0555;
    b_in  = 15'h0222;
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("ignore done", 32'(seen), 32'd1);
    check("ignore S", 32'(s_out), 32'h0030);
    check("ignore Carry", 32'(carry_out), 32'd0);
    check("ignore Overflow", 32'(ovf_out), 32'd0);
    last_exp = {1'b0, 1'b0, 15'h0030};
    run_op(15'h0001, 15'h0001, 1'b1, {1'b1, 1'b0, 15'h0000}, "b2b");

    // asynchronous reset mid-run discards the operation
    @(negedge clk);
    run_op(15'd100, 15'd23, 1'b0, {1'b0, 1'b0, 15'd123}, "pre_rst");
    @(negedge clk);
    a_in  = 15'h1234;
    b_in  = 15'h0111;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done || busy) quiet = 0;
    end
    check("mid_rst no_done", 32'(quiet), 32'd1);
    last_exp = '0;
    run_op(15'd1, 15'd1, 1'b0, {1'b0, 1'b0, 15'd2}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
